// File: rtl/inc16_pkg.sv
// rtl/inc16_pkg.sv - shared width and word type for the 16-bit incrementer
package inc16_pkg;

    localparam int INC16_WIDTH = 16;

    typedef logic [INC16_WIDTH-1:0] word_t;

endpackage

// File: rtl/half_adder.sv
// rtl/half_adder.sv - single-bit half adder cell used in the increment ripple chain
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b;
    assign cout = a & b;

endmodule

// File: rtl/student_inc16.sv
// rtl/student_inc16.sv - combinational in+1 incrementer, optional sticky wrap flag (INC16_OVF_STICKY_EN)
import inc16_pkg::*;

module student_inc16 #(
    parameter int WIDTH = INC16_WIDTH
) (
    input  logic  clk,
    input  logic  rst,
    input  word_t in,
    output word_t out,
    output logic  carry,
    output logic  ovf_sticky
);

    // Carry chain: c[0] is the constant +1 injected at bit 0.
    logic [WIDTH:0] c;

    assign c[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        half_adder u_ha (
            .a    (in[i]),
            .b    (c[i]),
            .sum  (out[i]),
            .cout (c[i+1])
        );
    end

    assign carry = c[WIDTH];

`ifdef INC16_OVF_STICKY_EN
    // Latch any wrap-around until reset; reset takes priority over a same-edge wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (carry) begin
            ovf_sticky <= 1'b1;
        end
    end
`else
    // Clock and reset only serve the sticky flag, which is absent in this build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_student_inc16.sv
// tb/tb_student_inc16.sv - directed and exhaustive self-checking bench for student_inc16
module tb_student_inc16;

    logic        clk;
    logic        rst;
    logic [15:0] in;
    logic [15:0] out;
    logic        carry;
    logic        ovf_sticky;

    int n_assert;
    int n_fail;

    student_inc16 dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .out        (out),
        .carry      (carry),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in       = 16'h0000;

        // Reset state of the sticky flag.
        @(posedge clk);
        #1;
        check1("reset_sticky", ovf_sticky, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, evaluated #1 after the input change.
        in = 16'h0000; #1;
        check16("out_0000", out, 16'h0001);
        check1("carry_0000", carry, 1'b0);
        in = 16'hFFFF; #1;
        check16("out_ffff", out, 16'h0000);
        check1("carry_ffff", carry, 1'b1);
        in = 16'h0005; #1;
        check16("out_0005", out, 16'h0006);
        check1("carry_0005", carry, 1'b0);
        in = 16'hFFFB; #1;
        check16("out_fffb", out, 16'hFFFC);
        check1("carry_fffb", carry, 1'b0);
        in = 16'h00FF; #1;
        check16("out_00ff", out, 16'h0100);
        check1("carry_00ff", carry, 1'b0);
        in = 16'h7FFF; #1;
        check16("out_7fff", out, 16'h8000);
        check1("carry_7fff", carry, 1'b0);

        // Asserting rst must not disturb the combinational outputs.
        rst = 1'b1;
        in  = 16'h1234; #1;
        check16("out_rst_1234", out, 16'h1235);
        check1("carry_rst_1234", carry, 1'b0);
        rst = 1'b0;

        // Exhaustive sweep with rst toggling and the clock free-running.
        for (int v = 0; v < 65536; v++) begin
            logic [15:0] exp_out;
            exp_out = 16'(v + 1);
            if ((v % 4096) == 0) rst = ~rst;
            in = 16'(v);
            #1;
            check16("sweep_out", out, exp_out);
            check1("sweep_carry", carry, (v == 65535));
        end

`ifdef INC16_OVF_STICKY_EN
        @(negedge clk);
        rst = 1'b1;
        in  = 16'h0000;
        @(posedge clk); #1;
        check1("sticky_after_rst", ovf_sticky, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        in  = 16'hFFFF;
        @(posedge clk); #1;
        check1("sticky_set", ovf_sticky, 1'b1);

        @(negedge clk);
        in = 16'h0003;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check1("sticky_hold", ovf_sticky, 1'b1);
        end

        @(negedge clk);
        rst = 1'b1;
        in  = 16'hFFFF;
        @(posedge clk); #1;
        check1("sticky_rst_wins", ovf_sticky, 1'b0);
        check16("out_during_rst", out, 16'h0000);
        check1("carry_during_rst", carry, 1'b1);
`else
        @(negedge clk);
        rst = 1'b0;
        in  = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check1("sticky_tied_low", ovf_sticky, 1'b0);
        end
`endif

        @(negedge clk);
        rst = 1'b0;
        in  = 16'h0000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/student_inc16.md
Name: student_inc16

Overview:
- 16-bit incrementer: out = in + 1, modulo 2^WIDTH.
- Purely combinational datapath; a building block for the ALU/PC path of the CPU project.
- Clock and reset exist for the optional sticky-overflow register only; the increment result never depends on them.

Parameters:
- WIDTH, 16, data width in bits. Only 16 is required to be supported and verified.

Ports:
- clk  input  1  system clock; rising-edge active; used only by the optional feature.
- rst  input  1  synchronous, active-high reset; used only by the optional feature.
- in  input  WIDTH  operand.
- out  output  WIDTH  in + 1, truncated to WIDTH bits.
- carry  output  1  carry-out of the increment. 1 exactly when in is all ones; combinational.
- ovf_sticky  output  1  sticky wrap indicator. Driven only when INC16_OVF_STICKY_EN is defined; otherwise tied to 0.

Behaviour:
- out and carry are combinational with zero clock latency.
- They settle within the same timestep as any change on in, with no dependence on clk or rst.
- Arithmetic is unsigned modulo 2^16:
  - 16'h0000 -> 16'h0001, carry 0.
  - 16'h0005 -> 16'h0006, carry 0.
  - 16'hFFFB -> 16'hFFFC, carry 0.
  - 16'hFFFF -> 16'h0000, carry 1 (wrap-around).
- Structure: ripple chain of half adders.
  - Bit 0 adds constant 1 to in[0].
  - Bit i adds in[i] to the carry from bit i-1.
  - carry is the carry out of bit 15.
- No X propagation from clk/rst into out or carry; asserting rst has no effect on out or carry.
- X or Z on in may propagate to out; no sanitizing is required.

Optional Feature:
- Macro: INC16_OVF_STICKY_EN.
- When defined:
  - ovf_sticky is a flop clocked on the rising edge of clk.
  - When rst = 1 at an edge, ovf_sticky becomes 0.
  - Otherwise, when carry = 1 at an edge, ovf_sticky becomes 1 and holds until reset.
  - If rst and carry are both 1 at the same edge, reset wins and ovf_sticky = 0.
- When not defined:
  - ovf_sticky is constant 0.
  - No flops are inferred; clk and rst are unused.
- out and carry are identical in both builds.

Decomposition:
- Package inc16_pkg holds:
  - localparam INC16_WIDTH = 16.
  - typedef logic [INC16_WIDTH-1:0] word_t, used for the in and out port types.
- One sub-module, half_adder (inputs a, b; outputs sum, cout), instantiated WIDTH times in a generate loop.
- No other hierarchy.

Test Plan:
- in=16'h0000, check after #1 with no clock -> out=16'h0001, carry=0.
- in=16'hFFFF -> out=16'h0000, carry=1.
- in=16'h0005 -> out=16'h0006, carry=0; in=16'hFFFB -> out=16'hFFFC, carry=0.
- Exhaustive sweep of all 65536 inputs -> out == (in+1) & 16'hFFFF and carry == (in==16'hFFFF) for every value; toggling clk/rst during the sweep changes neither output.
- With INC16_OVF_STICKY_EN:
  - rst=1 for one edge -> ovf_sticky=0.
  - in=16'hFFFF for one edge -> ovf_sticky=1.
  - in=16'h0003 for several edges -> ovf_sticky stays 1.
  - rst=1 together with in=16'hFFFF at one edge -> ovf_sticky=0.
- Without the macro: drive in=16'hFFFF across clk edges -> ovf_sticky stays 0.
